jstk_spi_slave: RTL and testbench
=================================

# jstk_spi_slave

SPI responder that emulates a PmodJSTK joystick module on the slave side of the joystick link. It answers the 5-byte joystick frame read by the existing joystick SPI master, returning a coherent snapshot of X, Y and button inputs. It also decodes the master's LED command byte. Used as a bench/board stand-in for a physical joystick and as the loopback target for the joystick master.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop stages on SCLK/SS/MOSI before edge detection; minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- clr  in  1  reset; synchronous, active-high.
- x_in  in  10  X position to report.
- y_in  in  10  Y position to report.
- btn_in  in  3  {left, right, stick} buttons.
- SCLK  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- SS  in  1  slave select, active low.
- MOSI  in  1  master-to-slave data, MSB first.
- MISO  out  1  slave-to-master data, MSB first.
- led  out  2  LED bits from the last valid command byte.
- busy  out  1  high while a frame is in progress (SS low, synchronized).
- frame_done  out  1  one-cycle pulse when SS rises after at least 40 bits.
- frame_abort  out  1  one-cycle pulse when SS rises after 1–39 bits.

## Operation
- Synchronize SCLK, SS and MOSI through SYNC_STAGES flops, plus one history flop for edge detection.
- FSM states:
  - IDLE: waiting for SS to fall.
  - LOAD: single cycle.
  - SHIFT: active frame.
  - TAIL: after 40 bits, SS still low.
- IDLE -> LOAD on synchronized SS falling edge.
- LOAD:
  - Capture the 40-bit frame {x_in[7:0], 6'b0, x_in[9:8], y_in[7:0], 6'b0, y_in[9:8], 5'b0, btn_in}.
  - Drive bit 39 on MISO.
  - Clear bit and byte counters, then go to SHIFT.
- SHIFT:
  - On SCLK rising edge, sample MOSI into the rx byte register and increment the bit counter (3-bit, wraps 7->0 and increments the byte counter).
  - On SCLK falling edge, shift the tx register left and drive the next bit.
  - After the 40th rising edge, go to TAIL.
- TAIL: MISO=0; further SCLK edges are ignored.
- Any state except IDLE returns to IDLE on a synchronized SS rising edge:
  - From TAIL: pulse frame_done.
  - From SHIFT with bit count 1–39: pulse frame_abort.
  - With bit count 0: no pulse.
- Command byte: when byte 0 completes (8th rising edge), if rx[7]=1 then led <= rx[1:0]. Otherwise led holds.
- MOSI bytes 1–4 are received and discarded.
- Input changes during a frame never affect the frame in flight.
- MISO=0 whenever the FSM is in IDLE.
- Reset values: MISO=0, led=2'b00, busy=0, frame_done=0, frame_abort=0, FSM=IDLE, counters=0.
- clr mid-frame: immediate return to IDLE with no pulse. The next SS falling edge is required to start a new frame; a frame already low at reset release is ignored until SS goes high then low.

## Timing
- Pin-to-internal latency: SYNC_STAGES+1 clk cycles (3 by default).
- MISO first bit is valid within SYNC_STAGES+2 clk of SS falling.
- MISO updates within SYNC_STAGES+2 clk of each SCLK falling edge.
- Requirement on the master: SCLK half-period ≥ 8 clk, and ≥ 8 clk from SS falling to first SCLK rising.
- led updates SYNC_STAGES+2 clk after the 8th SCLK rising edge.
- frame_done/frame_abort assert SYNC_STAGES+1 clk after SS rising.
- SS rising and SCLK edge in the same synchronized cycle: SS wins; the edge is dropped.

## Configuration
- JSTK_SLAVE_LED_CMD_EN defined: command byte decoded as above.
- Undefined: MOSI is neither sampled nor stored, led is constant 2'b00, and the rx register is removed. Framing, MISO and the pulses are unchanged.

## Test plan
- Reset: hold clr 2 cycles with SS=1 -> MISO=0, led=00, busy=0, no pulses.
- Full frame: x_in=0x2A5, y_in=0x13C, btn_in=3'b110; master sends 0x81,00,00,00,00 -> master receives A5,02,3C,01,06; led=01 after byte 0; one frame_done pulse, busy low after.
- Snapshot coherence: x_in changes 0x2A5->0x0FF after byte 1 -> current frame returns A5,02; next frame returns FF,00.
- Abort: SS rises after 12 bits -> single frame_abort pulse, no frame_done, led unchanged if byte 0 incomplete; the next full frame returns byte 0 correctly.
- Overrun and non-command: 48 SCLK cycles with first MOSI byte 0x03 -> bits 41–48 on MISO are 0; led holds its prior value; frame_done pulses once.
- clr mid-frame at bit 20 -> IDLE, MISO=0, no pulse; frame ignored until SS toggles high then low.
- Build with JSTK_SLAVE_LED_CMD_EN undefined: command 0x83 -> led stays 00, MISO data identical to enabled build.

Source files
------------

// File: rtl/jstk_spi_slave_if.sv
// SPI pin bundle for the PmodJSTK joystick link (mode 0, SS active low).
interface jstk_spi_slave_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (
    output SCLK,
    output SS,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCLK,
    input  SS,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/jstk_spi_slave.sv
// PmodJSTK joystick emulator on the slave side of the SPI link: returns a 5-byte X/Y/button snapshot.
// Optional macro JSTK_SLAVE_LED_CMD_EN enables decoding of the master's LED command byte.
module jstk_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [9:0]       x_in,
  input  logic [9:0]       y_in,
  input  logic [2:0]       btn_in,
  jstk_spi_slave_if.slave  spi,
  output logic [1:0]       led,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_abort
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;

  state_t state;
  state_t state_next;

  // Sync chains carry one extra history flop above the synchronized tap.
  // SS resets low so a frame already in progress at reset release is not seen as a falling edge.
  logic [SYNC_STAGES:0] sclk_sr;
  logic [SYNC_STAGES:0] ss_sr;
  logic sclk_s, sclk_h, ss_s, ss_h;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  always_ff @(posedge clk) begin
    if (clr) begin
      sclk_sr <= '0;
      ss_sr   <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], spi.SCLK};
      ss_sr   <= {ss_sr[SYNC_STAGES-1:0], spi.SS};
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sclk_h    = sclk_sr[SYNC_STAGES];
  assign ss_s      = ss_sr[SYNC_STAGES-1];
  assign ss_h      = ss_sr[SYNC_STAGES];
  assign sclk_rise = sclk_s & ~sclk_h;
  assign sclk_fall = ~sclk_s & sclk_h;
  assign ss_rise   = ss_s & ~ss_h;
  assign ss_fall   = ~ss_s & ss_h;

  logic [39:0] frame;
  logic [38:0] tx;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic        miso_q;
  logic        last_bit;
  logic        load_en, shift_en, sample_en, done_c, abort_c;

  assign frame    = {x_in[7:0], 6'b0, x_in[9:8], y_in[7:0], 6'b0, y_in[9:8], 5'b0, btn_in};
  assign last_bit = (byte_cnt == 3'd4) && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (ss_fall) state_next = LOAD;
      LOAD:  state_next = ss_rise ? IDLE : SHIFT;
      SHIFT: begin
        if (ss_rise)                    state_next = IDLE;
        else if (sclk_rise && last_bit) state_next = TAIL;
      end
      TAIL:  if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SS rising wins over a coincident SCLK edge: the edge enables are suppressed.
  always_comb begin
    load_en   = 1'b0;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD:  load_en = 1'b1;
      SHIFT: begin
        if (ss_rise) begin
          abort_c = (byte_cnt != 3'd0) || (bit_cnt != 3'd0);
        end else begin
          sample_en = sclk_rise;
          shift_en  = sclk_fall;
        end
      end
      TAIL:  done_c = ss_rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tx          <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      miso_q      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= done_c;
      frame_abort <= abort_c;

      if (load_en) begin
        tx       <= frame[38:0];
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (shift_en) begin
        tx <= {tx[37:0], 1'b0};
      end

      if (sample_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 3'd1;
      end

      if (state_next == IDLE || state_next == TAIL) miso_q <= 1'b0;
      else if (load_en)                             miso_q <= frame[39];
      else if (shift_en)                            miso_q <= tx[38];
    end
  end

  assign spi.MISO = miso_q;

`ifdef JSTK_SLAVE_LED_CMD_EN
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [7:0]             rx;
  logic                   cmd_pend;

  always_ff @(posedge clk) begin
    if (clr) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi.MOSI};
  end

  // Command applied one cycle after byte 0 lands in rx.
  always_ff @(posedge clk) begin
    if (clr) begin
      rx       <= '0;
      cmd_pend <= 1'b0;
      led      <= 2'b00;
    end else begin
      cmd_pend <= 1'b0;
      if (sample_en) begin
        rx <= {rx[6:0], mosi_sr[SYNC_STAGES-1]};
        if (byte_cnt == 3'd0 && bit_cnt == 3'd7) cmd_pend <= 1'b1;
      end
      if (cmd_pend && rx[7]) led <= rx[1:0];
    end
  end
`else
  assign led = 2'b00;
`endif

endmodule

// File: tb/tb_jstk_spi_slave.sv
// Directed bench for jstk_spi_slave: acts as the joystick SPI master and checks frames, pulses and led.
module tb_jstk_spi_slave;

  logic       clk;
  logic       clr;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic [2:0] btn_in;
  logic [1:0] led;
  logic       busy;
  logic       frame_done;
  logic       frame_abort;

  jstk_spi_slave_if spi_bus ();

  jstk_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .clr         (clr),
    .x_in        (x_in),
    .y_in        (y_in),
    .btn_in      (btn_in),
    .spi         (spi_bus),
    .led         (led),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

`ifdef JSTK_SLAVE_LED_CMD_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  localparam logic [47:0] FRAME_A = 48'hA5023C010600;
  localparam logic [47:0] FRAME_B = 48'hFF003C010600;
  localparam logic [47:0] FRAME_C = 48'hA50230000000;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int abort_cnt   = 0;

  logic [47:0] mi;
  int          lat;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode-0 master: 10 clk half-period, MOSI set while SCLK low, MISO sampled just before rising.
  task automatic run_frame(input string tag, input int nbits, input logic [7:0] cmd,
                           input int chg_at, input logic [9:0] chg_x, input int clr_at,
                           output logic [47:0] rx_bits, output int pulse_lat);
    logic [47:0] mo;
    mo        = {cmd, 40'h0};
    rx_bits   = '0;
    pulse_lat = -1;
    spi_bus.SS = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_busy_in"}, 48'(busy), 48'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) x_in = chg_x;
      if (i == clr_at) begin
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check({tag, "_busy_clr"}, 48'(busy), 48'd0);
        check({tag, "_miso_clr"}, 48'(spi_bus.MISO), 48'd0);
      end
      spi_bus.MOSI = mo[47-i];
      repeat (10) @(negedge clk);
      rx_bits[47-i] = spi_bus.MISO;
      spi_bus.SCLK = 1'b1;
      repeat (10) @(negedge clk);
      spi_bus.SCLK = 1'b0;
    end
    repeat (10) @(negedge clk);
    spi_bus.SS   = 1'b1;
    spi_bus.MOSI = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (pulse_lat < 0 && (frame_done || frame_abort)) pulse_lat = k;
    end
  endtask

  task automatic frame_checks(input string tag, input int nbits, input logic [47:0] exp_data,
                              input int d0, input int a0, input int exp_done, input int exp_abort,
                              input int exp_lat, input logic [1:0] exp_led);
    logic [47:0] mask;
    mask = ~48'h0 << (48 - nbits);
    check({tag, "_data"},  mi & mask, exp_data & mask);
    check({tag, "_done"},  48'(done_cnt - d0), 48'(exp_done));
    check({tag, "_abort"}, 48'(abort_cnt - a0), 48'(exp_abort));
    check({tag, "_lat"},   48'(lat), 48'(exp_lat));
    check({tag, "_led"},   48'(led), 48'(exp_led));
    check({tag, "_busy"},  48'(busy), 48'd0);
    check({tag, "_miso"},  48'(spi_bus.MISO), 48'd0);
  endtask

  initial begin
    int d0, a0;
    clr          = 1'b1;
    spi_bus.SS   = 1'b1;
    spi_bus.SCLK = 1'b0;
    spi_bus.MOSI = 1'b0;
    x_in   = '0;
    y_in   = '0;
    btn_in = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso",  48'(spi_bus.MISO), 48'd0);
    check("rst_led",   48'(led), 48'd0);
    check("rst_busy",  48'(busy), 48'd0);
    check("rst_done",  48'(done_cnt), 48'd0);
    check("rst_abort", 48'(abort_cnt), 48'd0);

    x_in   = 10'h2A5;
    y_in   = 10'h13C;
    btn_in = 3'b110;

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("full", 40, 8'h81, -1, 10'h0, -1, mi, lat);
    frame_checks("full", 40, FRAME_A, d0, a0, 1, 0, 3, LED_EN ? 2'b01 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("snap", 40, 8'h00, 16, 10'h0FF, -1, mi, lat);
    frame_checks("snap", 40, FRAME_A, d0, a0, 1, 0, 3, LED_EN ? 2'b01 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("snap_next", 40, 8'h00, -1, 10'h0, -1, mi, lat);
    frame_checks("snap_next", 40, FRAME_B, d0, a0, 1, 0, 3, LED_EN ? 2'b01 : 2'b00);

    x_in = 10'h2A5;
    d0 = done_cnt; a0 = abort_cnt;
    run_frame("abort5", 5, 8'h83, -1, 10'h0, -1, mi, lat);
    frame_checks("abort5", 5, FRAME_A, d0, a0, 0, 1, 3, LED_EN ? 2'b01 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("abort12", 12, 8'h82, -1, 10'h0, -1, mi, lat);
    frame_checks("abort12", 12, FRAME_A, d0, a0, 0, 1, 3, LED_EN ? 2'b10 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("after_abort", 40, 8'h00, -1, 10'h0, -1, mi, lat);
    frame_checks("after_abort", 40, FRAME_A, d0, a0, 1, 0, 3, LED_EN ? 2'b10 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("overrun", 48, 8'h03, -1, 10'h0, -1, mi, lat);
    frame_checks("overrun", 48, FRAME_A, d0, a0, 1, 0, 3, LED_EN ? 2'b10 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("cmd83", 40, 8'h83, -1, 10'h0, -1, mi, lat);
    frame_checks("cmd83", 40, FRAME_A, d0, a0, 1, 0, 3, LED_EN ? 2'b11 : 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("clr_mid", 40, 8'h81, -1, 10'h0, 20, mi, lat);
    frame_checks("clr_mid", 40, FRAME_C, d0, a0, 0, 0, -1, 2'b00);

    d0 = done_cnt; a0 = abort_cnt;
    run_frame("after_clr", 40, 8'h00, -1, 10'h0, -1, mi, lat);
    frame_checks("after_clr", 40, FRAME_A, d0, a0, 1, 0, 3, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
